// File: rtl/poly_sine_reader_pkg.sv
// Shared types, quadrant decode constants and default parameters for poly_sine_reader.
// Also holds the elaboration-time quarter-wave sine generator used to fill sine_rom.
package poly_sine_reader_pkg;

    localparam int unsigned DefNumCh   = 3;
    localparam int unsigned DefStepW   = 20;
    localparam int unsigned DefPhaseW  = 22;
    localparam int unsigned DefRomAw   = 10;
    localparam int unsigned DefSampleW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StAdv,
        StRead,
        StStore,
        StDone
    } state_e;

    // Bit positions within the 2-bit quadrant field.
    localparam int unsigned QuadMirrorBit = 0;
    localparam int unsigned QuadNegateBit = 1;

    // round(amp * sin(pi/2 * addr / 2^aw)) in Q30 fixed point, Taylor series to x^13.
    function automatic longint sine_q(int unsigned addr, int unsigned aw, int unsigned sw);
        longint pi_q30;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint amp;
        longint res;
        pi_q30 = 64'sd3373259426;
        x      = (pi_q30 * longint'(addr)) >>> (aw + 1);
        x2     = (x * x) >>> 30;
        term   = x;
        sum    = x;
        for (int k = 1; k <= 6; k++) begin
            term = (term * x2) >>> 30;
            term = term / longint'((2 * k) * (2 * k + 1));
            if ((k % 2) == 1) sum = sum - term;
            else              sum = sum + term;
        end
        amp = (longint'(1) << (sw - 1)) - 1;
        res = (sum * amp + (longint'(1) << 29)) >>> 30;
        if (res > amp) res = amp;
        if (res < 0)   res = 0;
        return res;
    endfunction

endpackage

// File: rtl/poly_sine_reader_rom.sv
// Quarter-wave sine ROM with a registered read port, shared by all channels.
module sine_rom
    import poly_sine_reader_pkg::*;
#(
    parameter int unsigned ROM_AW   = DefRomAw,
    parameter int unsigned SAMPLE_W = DefSampleW
) (
    input  logic                clk_i,
    input  logic [ROM_AW-1:0]   addr_i,
    output logic [SAMPLE_W-1:0] data_o
);

    localparam int unsigned Depth = 2 ** ROM_AW;

    logic [SAMPLE_W-1:0] table_w [Depth];
    logic [SAMPLE_W-1:0] data_q;

    for (genvar i = 0; i < Depth; i++) begin : g_table
        localparam logic [SAMPLE_W-1:0] Val = SAMPLE_W'(sine_q(i, ROM_AW, SAMPLE_W));
        assign table_w[i] = Val;
    end

    always_ff @(posedge clk_i) begin
        data_q <= table_w[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/poly_sine_reader.sv
// Multi-channel DDS sine reader: one time-multiplexed quarter-wave ROM, per-channel phases.
// Optional saturated channel sum output enabled by defining POLY_SINE_READER_SUM_EN.
module poly_sine_reader
    import poly_sine_reader_pkg::*;
#(
    parameter int unsigned NUM_CH   = DefNumCh,
    parameter int unsigned STEP_W   = DefStepW,
    parameter int unsigned PHASE_W  = DefPhaseW,
    parameter int unsigned ROM_AW   = DefRomAw,
    parameter int unsigned SAMPLE_W = DefSampleW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*STEP_W-1:0]     step_size,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         generate_next,
    output logic                         sample_ready,
    output logic                         busy,
    output logic [NUM_CH*SAMPLE_W-1:0]   sample,
`ifdef POLY_SINE_READER_SUM_EN
    output logic [SAMPLE_W-1:0]          sample_sum,
`endif
    output logic                         dropped
);

    localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                      state_q, state_d;
    logic [ChW-1:0]              ch_q, ch_d;
    logic [PHASE_W-1:0]          phase_q [NUM_CH];
    logic [PHASE_W-1:0]          phase_d [NUM_CH];
    logic [NUM_CH*SAMPLE_W-1:0]  sample_q, sample_d;
    logic                        en_q, en_d;
    logic                        gen_q;
    logic                        ready_q, ready_d;
    logic                        busy_q, busy_d;
    logic                        dropped_q, dropped_d;

    logic                        req;
    logic [PHASE_W-1:0]          cur_phase;
    logic [STEP_W-1:0]           cur_step;
    logic                        cur_en;
    logic [1:0]                  quad;
    logic [ROM_AW-1:0]           rom_addr;
    logic [SAMPLE_W-1:0]         rom_data;

    assign req      = generate_next & ~gen_q;
    assign quad     = cur_phase[PHASE_W-1 -: 2];
    assign rom_addr = quad[QuadMirrorBit] ? ~cur_phase[PHASE_W-3 -: ROM_AW]
                                          : cur_phase[PHASE_W-3 -: ROM_AW];

    sine_rom #(
        .ROM_AW   (ROM_AW),
        .SAMPLE_W (SAMPLE_W)
    ) u_rom (
        .clk_i  (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    always_comb begin
        cur_phase = '0;
        cur_step  = '0;
        cur_en    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == ChW'(i)) begin
                cur_phase = phase_q[i];
                cur_step  = step_size[i*STEP_W +: STEP_W];
                cur_en    = ch_enable[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        phase_d   = phase_q;
        sample_d  = sample_q;
        en_d      = en_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        dropped_d = dropped_q;

        if (req && state_q != StIdle) dropped_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StAdv;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            StAdv: begin
                en_d = cur_en;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_q == ChW'(i) && cur_en) begin
                        phase_d[i] = cur_phase + PHASE_W'(cur_step);
                    end
                end
                state_d = StRead;
            end
            StRead: state_d = StStore;
            StStore: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_q == ChW'(i)) begin
                        if (!en_q)                   sample_d[i*SAMPLE_W +: SAMPLE_W] = '0;
                        else if (quad[QuadNegateBit]) sample_d[i*SAMPLE_W +: SAMPLE_W] = -rom_data;
                        else                         sample_d[i*SAMPLE_W +: SAMPLE_W] = rom_data;
                    end
                end
                if (ch_q == ChW'(NUM_CH - 1)) begin
                    state_d = StDone;
                end else begin
                    ch_d    = ch_q + ChW'(1);
                    state_d = StAdv;
                end
            end
            StDone: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                ch_d    = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            phase_q   <= '{default: '0};
            sample_q  <= '0;
            en_q      <= 1'b0;
            gen_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            phase_q   <= phase_d;
            sample_q  <= sample_d;
            en_q      <= en_d;
            gen_q     <= generate_next;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign sample_ready = ready_q;
    assign busy         = busy_q;
    assign sample       = sample_q;
    assign dropped      = dropped_q;

`ifdef POLY_SINE_READER_SUM_EN
    localparam int unsigned SumW = SAMPLE_W + 4;
    localparam logic signed [SumW-1:0] SatMax = SumW'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [SumW-1:0] SatMin = -SatMax - SumW'(1);

    logic signed [SumW-1:0]  sum_full;
    logic [SAMPLE_W-1:0]     sum_q, sum_d;

    always_comb begin
        sum_full = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_full = sum_full + SumW'($signed(sample_q[i*SAMPLE_W +: SAMPLE_W]));
        end
        if (sum_full > SatMax)      sum_d = SatMax[SAMPLE_W-1:0];
        else if (sum_full < SatMin) sum_d = SatMin[SAMPLE_W-1:0];
        else                        sum_d = sum_full[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 sum_q <= '0;
        else if (state_q == StDone) sum_q <= sum_d;
    end

    assign sample_sum = sum_q;
`endif

endmodule
